// File: rtl/uart_debug_sched_pkg.sv
// Shared constants for the UART debug scheduler: command bytes, FSM state
// encodings, timing defaults and a small saturating-increment helper.
package uart_debug_sched_pkg;

    localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_NSTEP = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'
    localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'

    localparam int SEND_HIGH_DEF   = 4;
    localparam int DUMP_CYCLES_DEF = 416570;
    localparam int TIMER_W         = 20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GETCNT = 3'd1,
        ST_STEP   = 3'd2,
        ST_RUN    = 3'd3,
        ST_TRIG   = 3'd4,
        ST_WAIT   = 3'd5
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_debug_sched_if.sv
// Bundle of the command input from the UART receiver and the scheduler's
// control/debug outputs. slave = scheduler side, master = driver/observer side.
interface uart_debug_sched_if;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        cpu_step_en;
    logic        send_clk;
    logic        busy;
    logic [2:0]  state;
    logic [31:0] step_cnt;
    logic [7:0]  drop_cnt;

    modport slave (
        input  rx_done, rx_data,
        output cpu_step_en, send_clk, busy, state, step_cnt, drop_cnt
    );

    modport master (
        output rx_done, rx_data,
        input  cpu_step_en, send_clk, busy, state, step_cnt, drop_cnt
    );
endinterface

// File: rtl/uart_debug_sched_dbg_down_timer.sv
// Loadable down-counter shared by the STEP count, TRIG hold and WAIT window.
// zero is derived from the count register only, so it is glitch-free.
module dbg_down_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_reg;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);
endmodule

// File: rtl/uart_debug_sched.sv
// Debug-session scheduler: decodes UART command bytes, gates the CPU clock
// enable for single/N-step and free-run, fires the trace-dump trigger and
// holds off further commands until the dump window has elapsed.
module uart_debug_sched
    import uart_debug_sched_pkg::*;
#(
    parameter int SEND_HIGH   = SEND_HIGH_DEF,
    parameter int DUMP_CYCLES = DUMP_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    uart_debug_sched_if.slave  dbg
);
    // Timers are loaded with (length - 1) so the loaded state lasts exactly
    // "length" cycles including the cycle it is entered.
    localparam logic [TIMER_W-1:0] TRIG_LOAD = TIMER_W'(SEND_HIGH - 1);
    localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(DUMP_CYCLES - 1);

    state_t       state_reg;
    logic         step_en_reg;
    logic         send_clk_reg;
    logic         busy_reg;
    logic [31:0]  step_cnt_reg;
    logic [7:0]   drop_cnt_reg;

    logic               tmr_load;
    logic               tmr_en;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_zero;
    logic               drop_evt;
    logic               known_cmd;

    dbg_down_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Timer control and drop detection, decoded from the current state.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_val   = '0;
        known_cmd = (dbg.rx_data == CMD_STEP) || (dbg.rx_data == CMD_NSTEP) ||
                    (dbg.rx_data == CMD_RUN)  || (dbg.rx_data == CMD_DUMP);
        drop_evt  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (dbg.rx_done) begin
                    drop_evt = !known_cmd;
                    if (dbg.rx_data == CMD_STEP) begin
                        tmr_load = 1'b1;
                        tmr_val  = '0;
                    end else if (dbg.rx_data == CMD_DUMP) begin
                        tmr_load = 1'b1;
                        tmr_val  = TRIG_LOAD;
                    end
                end
            end
            ST_GETCNT: begin
                // count-1 in 8 bits: byte 0 wraps to 255, i.e. 256 steps.
                if (dbg.rx_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = {{(TIMER_W-8){1'b0}}, dbg.rx_data - 8'd1};
                end
            end
            ST_STEP: begin
                drop_evt = dbg.rx_done;
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TRIG_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_TRIG: begin
                drop_evt = dbg.rx_done;
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = WAIT_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WAIT: begin
                drop_evt = dbg.rx_done;
                tmr_en   = 1'b1;
            end
            ST_RUN: begin
                drop_evt = dbg.rx_done && (dbg.rx_data != CMD_PAUSE);
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    // Main FSM with registered outputs and the two statistics counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            step_en_reg  <= 1'b0;
            send_clk_reg <= 1'b0;
            busy_reg     <= 1'b0;
            step_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            step_cnt_reg <= step_cnt_reg + {31'd0, step_en_reg};
            if (drop_evt) begin
                drop_cnt_reg <= sat_inc8(drop_cnt_reg);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (dbg.rx_done) begin
                        case (dbg.rx_data)
                            CMD_STEP: begin
                                state_reg   <= ST_STEP;
                                step_en_reg <= 1'b1;
                                busy_reg    <= 1'b1;
                            end
                            CMD_NSTEP: begin
                                state_reg <= ST_GETCNT;
                                busy_reg  <= 1'b1;
                            end
                            CMD_RUN: begin
                                state_reg   <= ST_RUN;
                                step_en_reg <= 1'b1;
                            end
                            CMD_DUMP: begin
                                state_reg    <= ST_TRIG;
                                send_clk_reg <= 1'b1;
                                busy_reg     <= 1'b1;
                            end
                            default: state_reg <= ST_IDLE;
                        endcase
                    end
                end
                ST_GETCNT: begin
                    if (dbg.rx_done) begin
                        state_reg   <= ST_STEP;
                        step_en_reg <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (tmr_zero) begin
                        state_reg    <= ST_TRIG;
                        step_en_reg  <= 1'b0;
                        send_clk_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (dbg.rx_done && (dbg.rx_data == CMD_PAUSE)) begin
                        state_reg   <= ST_IDLE;
                        step_en_reg <= 1'b0;
                    end
                end
                ST_TRIG: begin
                    if (tmr_zero) begin
                        state_reg    <= ST_WAIT;
                        send_clk_reg <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (tmr_zero) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    step_en_reg  <= 1'b0;
                    send_clk_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign dbg.cpu_step_en = step_en_reg;
    assign dbg.send_clk    = send_clk_reg;
    assign dbg.busy        = busy_reg;
    assign dbg.state       = state_reg;
    assign dbg.step_cnt    = step_cnt_reg;
    assign dbg.drop_cnt    = drop_cnt_reg;
endmodule

// File: tb/tb_uart_debug_sched.sv
// Directed bench for uart_debug_sched with DUMP_CYCLES=100, SEND_HIGH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_debug_sched;
    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;
    int   n;

    always #5 clk = ~clk;

    uart_debug_sched_if dbg();

    uart_debug_sched #(.SEND_HIGH(4), .DUMP_CYCLES(100)) dut (
        .clk   (clk),
        .reset (reset),
        .dbg   (dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Called on a falling edge: one-cycle rx_done pulse, returns on the next
    // falling edge, where the response to the byte is visible.
    task automatic send(input logic [7:0] b);
        dbg.rx_done = 1'b1;
        dbg.rx_data = b;
        @(negedge clk);
        dbg.rx_done = 1'b0;
        $display("tx byte %02h -> state=%0d step_en=%0b send_clk=%0b busy=%0b step_cnt=%0d drop_cnt=%0d",
                 b, dbg.state, dbg.cpu_step_en, dbg.send_clk, dbg.busy, dbg.step_cnt, dbg.drop_cnt);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (dbg.busy === 1'b1 && k < 1000) begin
            tick(1);
            k++;
        end
        chk(tag, {31'd0, dbg.busy}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        dbg.rx_done = 1'b0;
        dbg.rx_data = 8'h00;
        tick(2);
        chk("rst_state",    {29'd0, dbg.state}, 32'd0);
        chk("rst_step_en",  {31'd0, dbg.cpu_step_en}, 32'd0);
        chk("rst_send_clk", {31'd0, dbg.send_clk}, 32'd0);
        chk("rst_busy",     {31'd0, dbg.busy}, 32'd0);
        chk("rst_step_cnt", dbg.step_cnt, 32'd0);
        chk("rst_drop_cnt", {24'd0, dbg.drop_cnt}, 32'd0);
        reset = 1'b0;
        tick(1);

        // Single step with exact latency
        send(8'h53);
        chk("s_state_step", {29'd0, dbg.state}, 32'd2);
        chk("s_en_t1",      {31'd0, dbg.cpu_step_en}, 32'd1);
        tick(1);
        chk("s_en_t2",      {31'd0, dbg.cpu_step_en}, 32'd0);
        chk("s_send_t2",    {31'd0, dbg.send_clk}, 32'd1);
        chk("s_state_trig", {29'd0, dbg.state}, 32'd4);
        tick(3);
        chk("s_send_t5",    {31'd0, dbg.send_clk}, 32'd1);
        tick(1);
        chk("s_send_t6",    {31'd0, dbg.send_clk}, 32'd0);
        chk("s_state_wait", {29'd0, dbg.state}, 32'd5);
        tick(99);
        chk("s_busy_t105",  {31'd0, dbg.busy}, 32'd1);
        tick(1);
        chk("s_busy_t106",  {31'd0, dbg.busy}, 32'd0);
        chk("s_state_idle", {29'd0, dbg.state}, 32'd0);
        chk("s_step_cnt",   dbg.step_cnt, 32'd1);

        // N-step with count 5
        send(8'h4E);
        chk("n5_getcnt", {29'd0, dbg.state}, 32'd1);
        send(8'h05);
        n = 0;
        while (dbg.cpu_step_en === 1'b1 && n < 400) begin n++; tick(1); end
        chk("n5_len", n, 5);
        n = 0;
        while (dbg.send_clk === 1'b1 && n < 50) begin n++; tick(1); end
        chk("n5_send_len", n, 4);
        wait_idle("n5_idle");
        chk("n5_step_cnt", dbg.step_cnt, 32'd6);

        // N-step with count byte 0 = 256
        send(8'h4E);
        send(8'h00);
        n = 0;
        while (dbg.cpu_step_en === 1'b1 && n < 400) begin n++; tick(1); end
        chk("n0_len", n, 256);
        wait_idle("n0_idle");
        chk("n0_step_cnt", dbg.step_cnt, 32'd262);

        // Invalid byte in IDLE
        send(8'h41);
        chk("inv_drop",  {24'd0, dbg.drop_cnt}, 32'd1);
        chk("inv_state", {29'd0, dbg.state}, 32'd0);

        // Free run, dropped 'S', pause
        send(8'h52);
        chk("run_state", {29'd0, dbg.state}, 32'd3);
        chk("run_en",    {31'd0, dbg.cpu_step_en}, 32'd1);
        chk("run_busy",  {31'd0, dbg.busy}, 32'd0);
        tick(50);
        send(8'h53);
        chk("run_s_drop",  {24'd0, dbg.drop_cnt}, 32'd2);
        chk("run_s_state", {29'd0, dbg.state}, 32'd3);
        send(8'h50);
        chk("pause_state", {29'd0, dbg.state}, 32'd0);
        chk("pause_en",    {31'd0, dbg.cpu_step_en}, 32'd0);
        chk("pause_cnt",   dbg.step_cnt, 32'd314);
        chk("pause_send",  {31'd0, dbg.send_clk}, 32'd0);
        tick(1);
        chk("pause_cnt_hold", dbg.step_cnt, 32'd314);

        // Dump only, three bytes dropped during WAIT
        send(8'h44);
        chk("d_state", {29'd0, dbg.state}, 32'd4);
        chk("d_send",  {31'd0, dbg.send_clk}, 32'd1);
        chk("d_en",    {31'd0, dbg.cpu_step_en}, 32'd0);
        tick(3);
        chk("d_send_last", {31'd0, dbg.send_clk}, 32'd1);
        tick(1);
        chk("d_wait", {29'd0, dbg.state}, 32'd5);
        send(8'h53);
        send(8'h52);
        send(8'h44);
        chk("d_drop",      {24'd0, dbg.drop_cnt}, 32'd5);
        chk("d_wait_hold", {29'd0, dbg.state}, 32'd5);
        wait_idle("d_idle");
        chk("d_step_cnt", dbg.step_cnt, 32'd314);

        // Saturation of drop_cnt
        for (int i = 0; i < 300; i++) send(8'h41);
        chk("sat_drop",  {24'd0, dbg.drop_cnt}, 32'd255);
        chk("sat_state", {29'd0, dbg.state}, 32'd0);

        // Asynchronous reset mid-WAIT, then normal operation
        send(8'h53);
        tick(10);
        chk("mid_wait", {29'd0, dbg.state}, 32'd5);
        #2 reset = 1'b1;
        #1;
        chk("ar_state",    {29'd0, dbg.state}, 32'd0);
        chk("ar_busy",     {31'd0, dbg.busy}, 32'd0);
        chk("ar_step_cnt", dbg.step_cnt, 32'd0);
        chk("ar_drop_cnt", {24'd0, dbg.drop_cnt}, 32'd0);
        chk("ar_send",     {31'd0, dbg.send_clk}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        send(8'h53);
        chk("ar_s_state", {29'd0, dbg.state}, 32'd2);
        chk("ar_s_en",    {31'd0, dbg.cpu_step_en}, 32'd1);
        tick(1);
        chk("ar_s_send",  {31'd0, dbg.send_clk}, 32'd1);
        chk("ar_s_cnt",   dbg.step_cnt, 32'd1);
        wait_idle("ar_s_idle");
        chk("ar_s_final", {29'd0, dbg.state}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
